spi_flash_responder: RTL
========================

# spi_flash_responder

Synthesizable SPI NOR-flash responder: the device-side end of the SoC's flash SPI master port (`io_flash_spi_*`). It oversamples SCK, CS and MOSI on the system clock and answers READ (0x03), JEDEC ID (0x9F) and READ STATUS (0x05) commands. Data comes from an internal byte memory preloaded through a side port. It is used in SoC-level benches and FPGA bring-up in place of an external flash part.

## Interface
- `MEM_BYTES`, 4096: internal memory size in bytes; must be a power of two. `AW = log2(MEM_BYTES)`.
- `JEDEC_ID`, 24'hEF4016: returned by 0x9F, MSB byte first.
- `clock` in 1: single system clock. All logic runs on its rising edge.
- `reset` in 1: synchronous, active-high reset.
- `spi_clk` in 1: SCK from the master. Asynchronous to `clock`.
- `spi_cs` in 1: chip select, active low. Asynchronous to `clock`.
- `spi_mosi` in 1: master-out data. Asynchronous to `clock`.
- `spi_miso` out 1: responder-out data.
- `load_valid` in 1: preload write strobe.
- `load_addr` in AW: preload byte address.
- `load_data` in 8: preload byte.
- `busy` out 1: high while synchronized CS is low.
- `cmd_count` out 16: number of recognized commands. Wraps 0xFFFF→0.
- `err_unknown_cmd` out 1: one-cycle pulse when an unrecognized opcode is received.

## Operation
- **Synchronization.** `spi_clk`, `spi_cs` and `spi_mosi` each pass through 2 flops. SCK rise/fall events are detected from the synchronized value and its 1-cycle-delayed copy.
- **SPI mode.** Mode 0, MSB first. MOSI is sampled on SCK rise. MISO is updated after SCK fall.
- **States:**
  - IDLE: CS high.
  - CMD: 8 opcode bits.
  - ADDR: 24 address bits.
  - DATA: READ output.
  - ID: JEDEC output.
  - STAT: status output.
  - IGNORE: unknown opcode.
- **Transitions:**
  - IDLE→CMD on synchronized CS falling.
  - After the 8th opcode bit:
    - 0x03 → ADDR.
    - 0x9F → ID.
    - 0x05 → STAT.
    - Any other opcode → IGNORE, and `err_unknown_cmd` pulses.
  - ADDR→DATA after the 24th address bit.
  - Any state → IDLE on synchronized CS high, regardless of bit position. The partial command is discarded and the bit counter is cleared.
- **`cmd_count`.** Increments once, in the cycle the 8th opcode bit is sampled, only for 0x03, 0x9F or 0x05.
- **READ.**
  - Only address bits [AW-1:0] are used; the upper bits are ignored.
  - On the 24th address-bit rise, the memory is read (registered, 1 cycle) and the byte is loaded into the 8-bit shift register.
  - Each subsequent byte boundary increments the address, wrapping MEM_BYTES-1→0.
  - Reading continues until CS rises.
- **ID.** Outputs JEDEC_ID[23:16], [15:8], [7:0], then 0x00 for every further byte.
- **STAT.** Outputs 0x00 repeatedly (WIP=0, WEL=0).
- **MISO driving.**
  - MISO presents shift[7] after each SCK fall during an output state.
  - The first output bit appears after the SCK fall that follows the last command/address rise.
  - MISO is 0 in IDLE, CMD, ADDR and IGNORE.
- **Preload.**
  - When `load_valid`=1 and `busy`=0: mem[load_addr] ← load_data in that cycle.
  - When `busy`=1: `load_valid` is ignored (no write).
- **Memory contents.** Not cleared by reset.

## Timing
- **Reset values:** `spi_miso`=0, `busy`=0, `cmd_count`=0, `err_unknown_cmd`=0, state=IDLE, bit counter=0.
- **Reset mid-transfer.** Aborts to IDLE. With CS still low afterwards, the responder stays in IGNORE-equivalent silence: it treats itself as IDLE and waits for a CS rise then fall before decoding.
- **SCK constraints.** SCK high and low phases each ≥4 `clock` periods. CS setup before the first SCK rise is ≥4 `clock` periods.
- **Input latency.** Sample point is 3 `clock` cycles after the pin edge (2 sync + 1 edge detect).
- **MISO latency.** MISO is valid ≤4 `clock` cycles after the SCK fall pin edge, before the next SCK rise under the constraint above.
- **`busy` latency.** `busy` follows the CS pin with 2 cycles of latency.
- **`err_unknown_cmd`.** Exactly 1 cycle wide.
- **Simultaneous events.** If a CS rise and an SCK edge are detected in the same cycle, CS wins and the edge is discarded.

## Test plan
- **Preload and READ.** Preload mem[0x000]=0xA5, mem[0x001]=0x3C. Send 03 00 00 00 plus 16 SCKs. MISO bytes must be A5, 3C; `cmd_count`=1; `busy` high throughout.
- **Address wrap.** Preload mem[0xFFF]=0x11, mem[0x000]=0x22. READ at 0x00FFFF (upper bits ignored) with 16 SCKs → 11, 22.
- **JEDEC ID.** 9F plus 32 SCKs → EF, 40, 16, 00. Then send 05 plus 8 SCKs → 00. `cmd_count` increments by 2.
- **Unknown opcode.** Send 0xAB plus 16 SCKs → `err_unknown_cmd` is a single 1-cycle pulse after the 8th bit; MISO stays 0; `cmd_count` is unchanged.
- **Abort then recover.** Raise CS after 12 address bits of a READ, then issue a full READ at 0x000001 → returns mem[0x001]=0x3C. The aborted command's partial bits must have no effect.
- **Preload and reset during activity.**
  - Assert `load_valid` (addr 0x000, data 0xFF) while `busy`=1 → mem[0x000] remains 0xA5.
  - Assert `reset` mid-DATA → all outputs return to their reset values on the next cycle.
  - The following CS-framed READ still returns 0xA5.

Source files
------------

// File: rtl/spi_flash_responder_if.sv
// SPI pin bundle between a flash master and the flash-side responder.
// The master drives SCK/CS/MOSI; the responder drives MISO.
interface spi_flash_responder_if;
   logic spi_clk;
   logic spi_cs;
   logic spi_mosi;
   logic spi_miso;

   modport master (output spi_clk, spi_cs, spi_mosi, input spi_miso);
   modport slave  (input spi_clk, spi_cs, spi_mosi, output spi_miso);
endinterface

// File: rtl/spi_flash_responder.sv
// SPI NOR-flash responder (mode 0): oversamples the SPI pins on the system clock and
// serves READ (03), JEDEC ID (9F) and READ STATUS (05) from a preloadable byte memory.
module spi_flash_responder #(
   parameter int          MEM_BYTES = 4096,
   parameter logic [23:0] JEDEC_ID  = 24'hEF4016
) (
   input  logic                         clock,
   input  logic                         reset,
   spi_flash_responder_if.slave         spi,
   input  logic                         load_valid,
   input  logic [$clog2(MEM_BYTES)-1:0] load_addr,
   input  logic [7:0]                   load_data,
   output logic                         busy,
   output logic [15:0]                  cmd_count,
   output logic                         err_unknown_cmd
);
   localparam int AW = $clog2(MEM_BYTES);
   // Sync reset values {sck, cs, mosi} match an idle bus: SCK low, CS deasserted.
   localparam logic [2:0] SYNC_RST = 3'b010;

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR, S_DATA, S_ID, S_STAT, S_IGNORE
   } state_t;

   logic [2:0] pin_raw;
   logic [2:0] sync_vec;
   logic       meta_cs;
   logic       sck_s, cs_s, mosi_s;
   logic       sck_rise, sck_fall;

   assign pin_raw = {spi.spi_clk, spi.spi_cs, spi.spi_mosi};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_sync
         logic meta_reg;
         logic sync_reg;
         always_ff @(posedge clock) meta_reg <= pin_raw[gi];
         always_ff @(posedge clock) begin
            if (reset) sync_reg <= SYNC_RST[gi];
            else       sync_reg <= meta_reg;
         end
         assign sync_vec[gi] = sync_reg;
         if (gi == 1) begin : g_cs_tap
            assign meta_cs = meta_reg;
         end
      end
   endgenerate

   assign sck_s  = sync_vec[2];
   assign cs_s   = sync_vec[1];
   assign mosi_s = sync_vec[0];

   state_t          state_reg, state_next;
   logic [4:0]      bit_cnt_reg, bit_cnt_next;
   logic [AW-2:0]   rx_reg, rx_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic [7:0]      shift_reg, shift_next;
   logic [2:0]      out_cnt_reg, out_cnt_next;
   logic [1:0]      id_idx_reg, id_idx_next;
   logic            pending_reg, pending_next;
   logic            miso_reg, miso_next;
   logic [15:0]     cmd_count_reg, cmd_count_next;
   logic            err_reg, err_next;
   logic            armed_reg, armed_next;
   logic            sck_d_reg;
   logic [7:0]      mem_q_reg;
   logic [7:0]      opcode;
   logic [7:0]      id_byte;
   logic [7:0]      mem [MEM_BYTES];

   assign sck_rise = sck_s & ~sck_d_reg;
   assign sck_fall = ~sck_s & sck_d_reg;
   assign opcode   = {rx_reg[6:0], mosi_s};

   always_ff @(posedge clock) begin
      if (load_valid && !busy) mem[load_addr] <= load_data;
      mem_q_reg <= mem[addr_next];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_reg     <= S_IDLE;
         bit_cnt_reg   <= '0;
         rx_reg        <= '0;
         addr_reg      <= '0;
         shift_reg     <= '0;
         out_cnt_reg   <= '0;
         id_idx_reg    <= '0;
         pending_reg   <= 1'b0;
         miso_reg      <= 1'b0;
         cmd_count_reg <= '0;
         err_reg       <= 1'b0;
         armed_reg     <= 1'b0;
         sck_d_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         bit_cnt_reg   <= bit_cnt_next;
         rx_reg        <= rx_next;
         addr_reg      <= addr_next;
         shift_reg     <= shift_next;
         out_cnt_reg   <= out_cnt_next;
         id_idx_reg    <= id_idx_next;
         pending_reg   <= pending_next;
         miso_reg      <= miso_next;
         cmd_count_reg <= cmd_count_next;
         err_reg       <= err_next;
         armed_reg     <= armed_next;
         sck_d_reg     <= sck_s;
      end
   end

   always_comb begin
      unique case (id_idx_reg)
         2'd1:    id_byte = JEDEC_ID[15:8];
         2'd2:    id_byte = JEDEC_ID[7:0];
         default: id_byte = 8'h00;
      endcase
   end

   always_comb begin
      state_next     = state_reg;
      bit_cnt_next   = bit_cnt_reg;
      rx_next        = rx_reg;
      addr_next      = addr_reg;
      shift_next     = shift_reg;
      out_cnt_next   = out_cnt_reg;
      id_idx_next    = id_idx_reg;
      pending_next   = pending_reg;
      miso_next      = miso_reg;
      cmd_count_next = cmd_count_reg;
      err_next       = 1'b0;
      // Decoding is only allowed after CS has really been seen high since reset.
      armed_next     = armed_reg | meta_cs;

      if (cs_s) begin
         state_next   = S_IDLE;
         bit_cnt_next = '0;
         out_cnt_next = '0;
         pending_next = 1'b0;
         miso_next    = 1'b0;
      end else begin
         unique case (state_reg)
            S_IDLE: begin
               miso_next = 1'b0;
               if (armed_reg) begin
                  state_next   = S_CMD;
                  bit_cnt_next = '0;
               end
            end
            S_CMD: begin
               miso_next = 1'b0;
               if (sck_rise) begin
                  rx_next      = {rx_reg[AW-3:0], mosi_s};
                  bit_cnt_next = bit_cnt_reg + 5'd1;
                  if (bit_cnt_reg == 5'd7) begin
                     bit_cnt_next = '0;
                     out_cnt_next = '0;
                     unique case (opcode)
                        8'h03: begin
                           state_next     = S_ADDR;
                           cmd_count_next = cmd_count_reg + 16'd1;
                        end
                        8'h9F: begin
                           state_next     = S_ID;
                           shift_next     = JEDEC_ID[23:16];
                           id_idx_next    = 2'd1;
                           cmd_count_next = cmd_count_reg + 16'd1;
                        end
                        8'h05: begin
                           state_next     = S_STAT;
                           shift_next     = 8'h00;
                           cmd_count_next = cmd_count_reg + 16'd1;
                        end
                        default: begin
                           state_next = S_IGNORE;
                           err_next   = 1'b1;
                        end
                     endcase
                  end
               end
            end
            S_ADDR: begin
               miso_next = 1'b0;
               if (sck_rise) begin
                  rx_next      = {rx_reg[AW-3:0], mosi_s};
                  bit_cnt_next = bit_cnt_reg + 5'd1;
                  if (bit_cnt_reg == 5'd23) begin
                     state_next   = S_DATA;
                     bit_cnt_next = '0;
                     addr_next    = {rx_reg[AW-2:0], mosi_s};
                     pending_next = 1'b1;
                  end
               end
            end
            S_DATA, S_ID, S_STAT: begin
               // A pending load captures the registered memory read issued last cycle.
               if (pending_reg) begin
                  shift_next   = mem_q_reg;
                  pending_next = 1'b0;
               end else if (sck_fall) begin
                  miso_next    = shift_reg[7];
                  shift_next   = {shift_reg[6:0], 1'b0};
                  out_cnt_next = out_cnt_reg + 3'd1;
                  if (out_cnt_reg == 3'd7) begin
                     if (state_reg == S_DATA) begin
                        addr_next    = addr_reg + AW'(1);
                        pending_next = 1'b1;
                     end else if (state_reg == S_ID) begin
                        shift_next  = id_byte;
                        id_idx_next = (id_idx_reg == 2'd3) ? 2'd3 : id_idx_reg + 2'd1;
                     end else begin
                        shift_next = 8'h00;
                     end
                  end
               end
            end
            default: begin
               miso_next = 1'b0;
            end
         endcase
      end
   end

   always_comb begin
      spi.spi_miso    = miso_reg;
      busy            = ~cs_s;
      cmd_count       = cmd_count_reg;
      err_unknown_cmd = err_reg;
   end
endmodule
